sv_stream_bus_demux: RTL

SV_STREAM_BUS_DEMUX -- requirements
Module: sv_stream_bus_demux

---
 rtl/sv_stream_bus_demux.sv | 98 +++++++++
 1 files changed

// File: rtl/sv_stream_bus_demux.sv
// Byte-stream to address/data bus demultiplexer: assembles NB = (AW+DW)/8 bytes,
// address first and each field LSB first, into one bus beat with a single output register.
module sv_stream_bus_demux #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sti_vld,
    input  logic [7:0]    sti_bus,
    output logic          sti_rdy,
    output logic          bso_vld,
    output logic [AW-1:0] bso_adr,
    output logic [DW-1:0] bso_dat,
    input  logic          bso_rdy
);

    localparam int PW = AW + DW;
    localparam int NB = PW / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NB - 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    logic [CW-1:0] cnt_r;
    logic [7:0]    asm_r [0:NB-2];
    logic          bso_vld_r;
    logic [AW-1:0] bso_adr_r;
    logic [DW-1:0] bso_dat_r;

    logic          last_s;
    logic          st_xfer_s;
    logic          bus_xfer_s;
    logic          sti_rdy_s;
    logic [PW-1:0] pkt_s;

    // Handshake decode; the final byte is only refused while the output beat is stuck.
    always_comb begin
        last_s     = (cnt_r == LAST_CNT);
        bus_xfer_s = bso_vld_r & bso_rdy;
        sti_rdy_s  = ~rst & ~(last_s & bso_vld_r & ~bso_rdy);
        st_xfer_s  = sti_vld & sti_rdy_s;
    end

    // Full packet as it would look if the current byte is the last one.
    always_comb begin
        pkt_s = '0;
        for (int i = 0; i < NB - 1; i++) begin
            pkt_s[i*8 +: 8] = asm_r[i];
        end
        pkt_s[PW-8 +: 8] = sti_bus;
    end

    // Byte counter and output beat register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= '0;
            bso_vld_r <= 1'b0;
            bso_adr_r <= '0;
            bso_dat_r <= '0;
        end else if (st_xfer_s && last_s) begin
            cnt_r     <= '0;
            bso_vld_r <= 1'b1;
            bso_adr_r <= pkt_s[AW-1:0];
            bso_dat_r <= pkt_s[PW-1:AW];
        end else if (st_xfer_s) begin
            cnt_r     <= cnt_r + ONE_CNT;
            bso_vld_r <= bso_vld_r & ~bus_xfer_s;
        end else if (bus_xfer_s) begin
            bso_vld_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_r;
            bso_vld_r <= bso_vld_r;
        end
    end

    // Assembly register: bytes 0..NB-2 land in their own lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NB - 1; i++) begin
                asm_r[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NB - 1; i++) begin
                if (st_xfer_s && (cnt_r == CW'(i))) begin
                    asm_r[i] <= sti_bus;
                end else begin
                    asm_r[i] <= asm_r[i];
                end
            end
        end
    end

    assign sti_rdy = sti_rdy_s;
    assign bso_vld = bso_vld_r;
    assign bso_adr = bso_adr_r;
    assign bso_dat = bso_dat_r;

endmodule
